// File: rtl/sample_filter_if.sv
// Sample-path bus for sample_filter: input strobe/data/mode, output strobe/data/status.
// Member names match the filter's port list; the master drives the *_i side.
interface sample_filter_if #(
    parameter int DATA_W = 16
);
    logic                     clear_i;
    logic [1:0]               mode_i;
    logic                     valid_i;
    logic signed [DATA_W-1:0] data_i;
    logic                     ready_o;
    logic                     valid_o;
    logic signed [DATA_W-1:0] data_o;
    logic                     overrun_o;

    modport master (
        output clear_i, mode_i, valid_i, data_i,
        input  ready_o, valid_o, data_o, overrun_o
    );

    modport slave (
        input  clear_i, mode_i, valid_i, data_i,
        output ready_o, valid_o, data_o, overrun_o
    );
endinterface

// File: rtl/sample_filter.sv
// Four-mode sample filter (bypass / moving average / high-pass / invert) over a 2^LOG2_TAPS window.
// Optional macro FILTER_SATURATE_EN: saturate modes 2 and 3 instead of wrapping.
module sample_filter #(
    parameter int DATA_W    = 16,
    parameter int LOG2_TAPS = 3
) (
    input  logic           clk_i,
    input  logic           reset_i,
    sample_filter_if.slave bus
);
    localparam int TAPS  = 1 << LOG2_TAPS;
    localparam int SUM_W = DATA_W + LOG2_TAPS;
    localparam logic [LOG2_TAPS-1:0] LAST_IDX = LOG2_TAPS'(TAPS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_ACCUM,
        S_EMIT
    } state_t;

    state_t                   r_state;
    logic [LOG2_TAPS-1:0]     r_cnt;
    logic [LOG2_TAPS-1:0]     r_wr_ptr;
    logic signed [SUM_W-1:0]  r_sum;
    logic signed [DATA_W-1:0] r_x;
    logic [1:0]               r_mode;
    logic signed [DATA_W-1:0] r_data;
    logic                     r_valid;
    logic                     r_ready;
    logic                     r_overrun;

    logic signed [DATA_W-1:0] r_buf [TAPS];
    logic signed [DATA_W-1:0] r_old;

    logic                     w_we;
    logic [LOG2_TAPS-1:0]     w_waddr;
    logic signed [DATA_W-1:0] w_wdata;
    logic signed [DATA_W-1:0] w_avg;
    logic signed [DATA_W:0]   w_hp;
    logic signed [DATA_W:0]   w_neg;
    logic                     w_flush;

    // Dropping the low LOG2_TAPS bits is the arithmetic shift; the result always fits DATA_W.
    assign w_avg   = r_sum[SUM_W-1:LOG2_TAPS];
    assign w_hp    = {r_x[DATA_W-1], r_x} - {w_avg[DATA_W-1], w_avg};
    assign w_neg   = -{r_x[DATA_W-1], r_x};
    assign w_flush = reset_i | bus.clear_i;

    function automatic logic [DATA_W-1:0] narrow(input logic [DATA_W:0] v);
`ifdef FILTER_SATURATE_EN
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_ptr;
        w_wdata = r_x;
        if (!w_flush) begin
            if (r_state == S_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = '0;
            end else if (r_state == S_ACCUM) begin
                w_we = 1'b1;
            end
        end
    end

    // Window storage: one write port, registered read of the slot about to be replaced.
    always_ff @(posedge clk_i) begin
        if (w_we)
            r_buf[w_waddr] <= w_wdata;
        r_old <= r_buf[r_wr_ptr];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_CLEAR;
            r_cnt     <= '0;
            r_wr_ptr  <= '0;
            r_sum     <= '0;
            r_x       <= '0;
            r_mode    <= 2'd0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (bus.clear_i) begin
            // data_o and the latched mode survive a flush.
            r_state   <= S_CLEAR;
            r_cnt     <= '0;
            r_wr_ptr  <= '0;
            r_sum     <= '0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.valid_i && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_CLEAR: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_sum    <= '0;
                    r_wr_ptr <= '0;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.valid_i) begin
                        r_x     <= bus.data_i;
                        r_mode  <= bus.mode_i;
                        r_ready <= 1'b0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    r_sum    <= r_sum + {{LOG2_TAPS{r_x[DATA_W-1]}}, r_x}
                                      - {{LOG2_TAPS{r_old[DATA_W-1]}}, r_old};
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_state  <= S_EMIT;
                end
                S_EMIT: begin
                    case (r_mode)
                        2'd0:    r_data <= r_x;
                        2'd1:    r_data <= w_avg;
                        2'd2:    r_data <= narrow(w_hp);
                        default: r_data <= narrow(w_neg);
                    endcase
                    r_valid <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o   = r_ready;
    assign bus.valid_o   = r_valid;
    assign bus.data_o    = r_data;
    assign bus.overrun_o = r_overrun;
endmodule

// File: tb/tb_sample_filter.sv
// Directed bench for sample_filter with LOG2_TAPS=2 (4-tap window), hand-computed expectations.
module tb_sample_filter;
    localparam int DATA_W = 16;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   n_cmp   = 0;
    int   n_err   = 0;

    sample_filter_if #(.DATA_W(DATA_W)) bus ();

    sample_filter #(.DATA_W(DATA_W), .LOG2_TAPS(2)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("ready_timeout", bus.ready_o, 1);
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    // Accept at edge k, expect a single valid_o strobe in the cycle after edge k+3.
    task automatic feed(input string tag, input logic [1:0] mode,
                        input logic signed [DATA_W-1:0] din, input logic signed [31:0] exp);
        wait_ready();
        bus.mode_i  = mode;
        bus.data_i  = din;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        check({tag, "_v0"}, bus.valid_o, 0);
        tick();
        check({tag, "_v1"}, bus.valid_o, 0);
        tick();
        check({tag, "_v2"}, bus.valid_o, 0);
        tick();
        check({tag, "_v3"}, bus.valid_o, 1);
        check({tag, "_data"}, bus.data_o, exp);
        check({tag, "_rdy"}, bus.ready_o, 1);
        $display("txn %s mode=%0d in=%0d out=%0d exp=%0d", tag, mode, din, bus.data_o, exp);
        tick();
        check({tag, "_v4"}, bus.valid_o, 0);
        repeat (5) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic signed [31:0] inv_min;
        bus.clear_i = 1'b0;
        bus.mode_i  = 2'd0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;

        // 1: reset state and CLEAR duration
        tick();
        tick();
        check("rst_ready", bus.ready_o, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_ovr", bus.overrun_o, 0);
        reset_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("clr_ready_%0d", i), bus.ready_o, (i == 4) ? 1 : 0);
        end

        // 2: moving average
        feed("avg0", 2'd1, 16'sd400, 100);
        feed("avg1", 2'd1, 16'sd400, 200);
        feed("avg2", 2'd1, 16'sd400, 300);
        feed("avg3", 2'd1, 16'sd400, 400);
        feed("avg4", 2'd1, 16'sd0,   300);

        // 3: high-pass, then floor rounding of a negative average
        pulse_clear();
        feed("hp0", 2'd2, 16'sd400, 300);
        feed("hp1", 2'd2, 16'sd400, 200);
        feed("hp2", 2'd2, 16'sd400, 100);
        feed("hp3", 2'd2, 16'sd400, 0);
        feed("hp4", 2'd2, 16'sd0,   -300);
        pulse_clear();
        feed("floor", 2'd1, -16'sd1, -1);

        // 4: invert, including the overflowing corner
`ifdef FILTER_SATURATE_EN
        inv_min = 32767;
`else
        inv_min = -32768;
`endif
        feed("inv_min", 2'd3, -16'sd32768, inv_min);
        feed("inv5", 2'd3, 16'sd5, -5);

        // 5: back-to-back strobes -> overrun, second sample dropped
        wait_ready();
        check("ovr_pre", bus.overrun_o, 0);
        bus.mode_i  = 2'd0;
        bus.data_i  = 16'sd7;
        bus.valid_i = 1'b1;
        tick();
        bus.data_i = 16'sd9;
        tick();
        bus.valid_i = 1'b0;
        check("ovr_set", bus.overrun_o, 1);
        tick();
        check("ovr_v2", bus.valid_o, 0);
        tick();
        check("ovr_v3", bus.valid_o, 1);
        check("ovr_data", bus.data_o, 7);
        $display("txn ovr mode=0 in=7 out=%0d exp=7", bus.data_o);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.valid_o === 1'b1) pulses++;
        end
        check("ovr_pulses", pulses, 0);
        check("ovr_sticky", bus.overrun_o, 1);
        pulse_clear();
        check("ovr_cleared", bus.overrun_o, 0);
        check("clr_hold_data", bus.data_o, 7);
        wait_ready();

        // 6: clear during ACCUM aborts the sample and re-clears the window
        bus.mode_i  = 2'd1;
        bus.data_i  = 16'sd1000;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        tick();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        check("abort_ready", bus.ready_o, 0);
        pulses = 0;
        for (int i = 1; i <= 4; i++) begin
            if (bus.valid_o === 1'b1) pulses++;
            tick();
            check($sformatf("abort_clr_%0d", i), bus.ready_o, (i == 4) ? 1 : 0);
        end
        check("abort_novalid", pulses, 0);
        check("abort_hold", bus.data_o, 7);
        feed("post_clr", 2'd1, 16'sd800, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
